// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- time-multiplexed scan controller for a common-cathode
// multi-digit 7-segment display sharing one hex decoder.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   value_in, dp_in       display word (nibble i -> digit i) and dp bits
//   load_valid/ready      load handshake into the pending buffer
//   lz_suppress           leading-zero suppression enable (live)
//   digit_nibble          nibble for the shared decoder
//   digit_sel             one-hot digit enable, zero while blanked
//   dp_out                decimal point of the current digit
//   frame_done            pulse on the last cycle of each frame
//
// Each slot is PRESCALE cycles: BLANK_CYCLES with all digits off, then the
// digit is shown. New words land in a pending buffer and are copied to the
// active word only at the frame boundary, so a frame never mixes two words.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lz_suppress,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] active, active_nxt, pending;
  logic [NUM_DIGITS-1:0]   active_dp, active_dp_nxt, pending_dp;
  logic                    pend_full;
  logic                    slot_wrap, swap, take, frame_done_nxt, all_zero;
  logic [NUM_DIGITS-1:0]   lz_mask, sel_onehot, sel_nxt;
  logic [3:0]              nibble_nxt;
  logic                    dp_nxt;

  assign load_ready = !pend_full;

  // Outputs are registered but derived from the next cnt/idx/active values,
  // so each registered output lines up with the counter state of its cycle.
  always_comb begin
    slot_wrap = (cnt == CNT_LAST);
    cnt_nxt   = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    frame_done_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);

    take          = load_valid && !pend_full;
    swap          = frame_done && pend_full;
    active_nxt    = swap ? pending    : active;
    active_dp_nxt = swap ? pending_dp : active_dp;

    // lz_mask[i]: all active nibbles from the top down to i are zero.
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && (active_nxt[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end

    for (int i = 0; i < NUM_DIGITS; i++) sel_onehot[i] = (idx_nxt == IW'(i));

    // Suppression is decided at the BLANK->SHOW point; a suppressed digit
    // simply never leaves BLANK for that slot.
    state_nxt = state;
    case (state)
      ST_BLANK: if (cnt_nxt == CNT_SHOW && !(lz_suppress && lz_mask[idx_nxt]))
                  state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_wrap) state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase

    // Nibble is driven through BLANK too, so the decoder has settled on the
    // new digit before its enable rises.
    nibble_nxt = active_nxt[{idx_nxt, 2'b00} +: 4];
    sel_nxt    = (state_nxt == ST_SHOW) ? sel_onehot : '0;
    dp_nxt     = (state_nxt == ST_SHOW) && active_dp_nxt[idx_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      active_dp    <= '0;
      pending      <= '0;
      pending_dp   <= '0;
      pend_full    <= 1'b0;
      digit_nibble <= 4'h0;
      digit_sel    <= '0;
      dp_out       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      active       <= active_nxt;
      active_dp    <= active_dp_nxt;
      digit_nibble <= nibble_nxt;
      digit_sel    <= sel_nxt;
      dp_out       <= dp_nxt;
      frame_done   <= frame_done_nxt;
      // take and swap are exclusive: take needs pending empty, swap full.
      if (take) begin
        pending    <= value_in;
        pending_dp <= dp_in;
        pend_full  <= 1'b1;
      end else if (swap) begin
        pend_full  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// Table of {word, dp, lz, expected enabled-digit mask} records, each checked
// cycle by cycle over a whole frame, plus hand-written sequences for double
// buffering, frame-edge loads and mid-slot reset.
module tb_seg7_scan_ctrl;
  localparam int ND = 4, PS = 8, BC = 2, FL = ND * PS;

  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_valid = 1'b0, lz_suppress = 1'b0;
  logic        load_ready, dp_out, frame_done;
  logic [3:0]  digit_nibble, digit_sel;

  int n_chk = 0, n_pass = 0;
  int cyc;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
    .load_valid(load_valid), .load_ready(load_ready), .lz_suppress(lz_suppress),
    .digit_nibble(digit_nibble), .digit_sel(digit_sel), .dp_out(dp_out),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  // Reference position in the scan: cycles since reset release.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0; else cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
  endtask

  task automatic check_cycle(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    int  c, d;
    logic show;
    c = cyc % PS;
    d = (cyc / PS) % ND;
    show = (c >= BC) && en[d];
    chk("digit_sel", {28'd0, digit_sel}, show ? (32'd1 << d) : 32'd0);
    chk("dp_out", {31'd0, dp_out}, {31'd0, show && dp[d]});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (d == ND-1) && (c == PS-1)});
    if (show) chk("digit_nibble", {28'd0, digit_nibble}, {28'd0, 4'((v >> (4*d)) & 16'hF)});
  endtask

  // Check from the current cycle through the end of the current frame.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    for (int k = 0; k < FL; k++) begin
      bit last;
      last = (cyc % FL) == FL - 1;
      check_cycle(v, dp, en);
      @(negedge clk);
      if (last) break;
    end
  endtask

  task automatic wait_frame_done();
    for (int k = 0; k < 4*FL; k++) begin
      if (frame_done) break;
      @(negedge clk);
    end
    chk("wait_frame_done", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    value_in = v; dp_in = dp; load_valid = 1'b1;
    for (int k = 0; k < 4*FL; k++) begin
      if (load_ready) break;
      @(negedge clk);
    end
    chk("load_ready_wait", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  en;   // digits expected to light up
  } vec_t;
  vec_t vecs[7];

  initial begin
    bit early;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
    vecs[3] = '{16'h1000, 4'b0000, 1'b1, 4'b1111};
    vecs[4] = '{16'h5678, 4'b0100, 1'b0, 4'b1111};
    vecs[5] = '{16'h0050, 4'b1100, 1'b1, 4'b0011};
    vecs[6] = '{16'h0305, 4'b0000, 1'b1, 4'b0111};

    repeat (3) @(negedge clk);
    chk("rst_sel", {28'd0, digit_sel}, 32'd0);
    chk("rst_nibble", {28'd0, digit_nibble}, 32'd0);
    chk("rst_dp", {31'd0, dp_out}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      lz_suppress = vecs[i].lz;
      load_word(vecs[i].value, vecs[i].dp);
      wait_frame_done();
      @(negedge clk);
      run_frame(vecs[i].value, vecs[i].dp, vecs[i].en);
    end

    // Double buffer: 0x1111 taken at once, 0x2222 held until ready returns.
    lz_suppress = 1'b0;
    value_in = 16'h1111; dp_in = 4'b0000; load_valid = 1'b1;
    @(negedge clk);
    chk("db_ready_drop", {31'd0, load_ready}, 32'd0);
    value_in = 16'h2222;
    early = 1'b0;
    for (int k = 0; k < 4*FL; k++) begin
      if (frame_done) break;
      if (load_ready) early = 1'b1;
      @(negedge clk);
    end
    chk("db_ready_held", {31'd0, early}, 32'd0);
    chk("db_fd_reached", {31'd0, frame_done}, 32'd1);
    chk("db_ready_fd", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    chk("db_ready_rise", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    chk("db_accept2", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    run_frame(16'h1111, 4'b0000, 4'b1111);
    run_frame(16'h2222, 4'b0000, 4'b1111);

    // Frame-edge load: valid only during the frame_done cycle.
    wait_frame_done();
    value_in = 16'hABCD; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("fe_accept", {31'd0, load_ready}, 32'd0);
    run_frame(16'h2222, 4'b0000, 4'b1111);
    run_frame(16'hABCD, 4'b0000, 4'b1111);

    // Reset at idx 2, cnt 5 with the pending buffer full.
    load_word(16'h9999, 4'b1111);
    for (int k = 0; k < 4*FL; k++) begin
      if (cyc % FL == 2*PS + 5) break;
      @(negedge clk);
    end
    chk("pre_rst_sel", {28'd0, digit_sel}, 32'h4);
    chk("pre_rst_nibble", {28'd0, digit_nibble}, 32'hB);
    chk("pre_rst_ready", {31'd0, load_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_sel", {28'd0, digit_sel}, 32'd0);
    chk("mid_rst_nibble", {28'd0, digit_nibble}, 32'd0);
    chk("mid_rst_dp", {31'd0, dp_out}, 32'd0);
    chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_frame(16'h0000, 4'b0000, 4'b1111);
    run_frame(16'h0000, 4'b0000, 4'b1111);
    chk("post_rst_ready", {31'd0, load_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
